irq_controller: RTL and testbench

- Interrupt/exception sequencer between the peripheral bus devices (timer, UART) and the single-cycle MIPS core.
- Latches asynchronous-to-software events into pending bits, masks them and picks one by fixed priority.
- Presents one request plus a kernel vector to the core's PC logic and blocks nesting until the handler returns (jr $26).
- Vector slots match the instruction-memory layout: timer 0x004, exception 0x008, UART-send 0x00C, UART-receive 0x010.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_prio_enc.sv | 26 ++
 rtl/irq_controller.sv | 114 +++++++++++
 tb/tb_irq_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg : shared source indices, vector offsets and FSM encoding
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

    localparam logic [1:0] SRC_EXC   = 2'd0;
    localparam logic [1:0] SRC_TIMER = 2'd1;
    localparam logic [1:0] SRC_UTX   = 2'd2;
    localparam logic [1:0] SRC_URX   = 2'd3;

    localparam logic [31:0] OFF_TIMER = 32'h0000_0004;
    localparam logic [31:0] OFF_EXC   = 32'h0000_0008;
    localparam logic [31:0] OFF_UTX   = 32'h0000_000C;
    localparam logic [31:0] OFF_URX   = 32'h0000_0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc : 4-bit fixed-priority encoder, bit 0 highest
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [3:0] req,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = SRC_EXC;
        if (req[0])      idx = SRC_EXC;
        else if (req[1]) idx = SRC_TIMER;
        else if (req[2]) idx = SRC_UTX;
        else if (req[3]) idx = SRC_URX;
    end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller : latches, masks and prioritises interrupt sources, then
// sequences one request/ack/eret handshake with the core. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_controller
    import irq_pkg::*;
#(
    parameter logic        KBIT      = 1'b1,
    parameter logic [31:0] VEC_TIMER = OFF_TIMER,
    parameter logic [31:0] VEC_EXC   = OFF_EXC,
    parameter logic [31:0] VEC_UTX   = OFF_UTX,
    parameter logic [31:0] VEC_URX   = OFF_URX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_irq,
    input  logic        exc_req,
    input  logic        utx_done,
    input  logic        urx_done,
    input  logic        kernel_mode,
    input  logic        mask_we,
    input  logic [3:0]  mask_wdata,
    input  logic        int_ack,
    input  logic        eret,
    output logic        irq_out,
    output logic [31:0] vector_addr,
    output logic [1:0]  cause,
    output logic [3:0]  pending,
    output logic        in_service
);

    irq_state_t state, state_next;
    logic [3:0] mask;
    logic       timer_prev;
    logic [3:0] set_bits;
    logic [3:0] clr_bits;
    logic [3:0] eligible;
    logic       enc_valid;
    logic [1:0] enc_idx;
    logic       grant;

    function automatic logic [31:0] vec_of(input logic [1:0] src);
        logic [31:0] off;
        case (src)
            SRC_EXC:   off = VEC_EXC;
            SRC_TIMER: off = VEC_TIMER;
            SRC_UTX:   off = VEC_UTX;
            default:   off = VEC_URX;
        endcase
        return {KBIT, off[30:0]};
    endfunction

    always_comb begin
        set_bits = {urx_done, utx_done, timer_irq & ~timer_prev, exc_req};
        clr_bits = 4'b0000;
        if (state == ST_REQ && int_ack)
            clr_bits = 4'b0001 << cause;
        eligible = pending & ~mask;
    end

    irq_prio_enc u_prio (
        .req   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // In kernel mode only the exception may be taken; it is also the top priority.
    assign grant = enc_valid && (!kernel_mode || enc_idx == SRC_EXC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 4'b0000;
            mask       <= 4'b0000;
            timer_prev <= 1'b0;
        end else begin
            pending    <= (pending & ~clr_bits) | set_bits;
            timer_prev <= timer_irq;
            if (mask_we)
                mask <= {mask_wdata[3:1], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cause       <= SRC_EXC;
            vector_addr <= 32'h0000_0000;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && grant) begin
                cause       <= enc_idx;
                vector_addr <= vec_of(enc_idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant)   state_next = ST_REQ;
            ST_REQ:  if (int_ack) state_next = ST_SVC;
            ST_SVC:  if (eret)    state_next = ST_IDLE;
            default:              state_next = ST_IDLE;
        endcase
    end

    assign irq_out    = (state == ST_REQ);
    assign in_service = (state == ST_SVC);

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller : directed scenario bench for irq_controller
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timer_irq = 1'b0, exc_req = 1'b0, utx_done = 1'b0, urx_done = 1'b0;
    logic        kernel_mode = 1'b0, mask_we = 1'b0, int_ack = 1'b0, eret = 1'b0;
    logic [3:0]  mask_wdata = 4'b0000;
    logic        irq_out, in_service;
    logic [31:0] vector_addr;
    logic [1:0]  cause;
    logic [3:0]  pending;

    int total = 0;
    int bad   = 0;

    irq_controller dut (
        .clk         (clk),
        .reset       (reset),
        .timer_irq   (timer_irq),
        .exc_req     (exc_req),
        .utx_done    (utx_done),
        .urx_done    (urx_done),
        .kernel_mode (kernel_mode),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .int_ack     (int_ack),
        .eret        (eret),
        .irq_out     (irq_out),
        .vector_addr (vector_addr),
        .cause       (cause),
        .pending     (pending),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_and_return();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq_out); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b want=0000", pending); end
        total++; if (vector_addr !== 32'h0) begin bad++; $display("FAIL reset_vec got=%h want=0", vector_addr); end
        total++; if (cause !== 2'd0 || in_service !== 1'b0) begin bad++; $display("FAIL reset_cause_svc got=%0d/%b want=0/0", cause, in_service); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_urx_basic();
        urx_done = 1'b1; step(); urx_done = 1'b0;
        total++; if (pending !== 4'b1000 || irq_out !== 1'b0) begin bad++; $display("FAIL urx_pend got=%b/%b want=1000/0", pending, irq_out); end
        step();
        total++; if (irq_out !== 1'b1) begin bad++; $display("FAIL urx_irq got=%b want=1", irq_out); end
        total++; if (cause !== 2'd3 || vector_addr !== 32'h8000_0010) begin bad++; $display("FAIL urx_vec got=%0d/%h want=3/80000010", cause, vector_addr); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (pending !== 4'b0000 || in_service !== 1'b1 || irq_out !== 1'b0) begin bad++; $display("FAIL urx_ack got=%b/%b/%b want=0000/1/0", pending, in_service, irq_out); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (in_service !== 1'b0 || irq_out !== 1'b0) begin bad++; $display("FAIL urx_eret got=%b/%b want=0/0", in_service, irq_out); end
        step();
        total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL urx_idle got=%b want=0", irq_out); end
    endtask

    task automatic test_back_to_back();
        exc_req = 1'b1; utx_done = 1'b1; step(); exc_req = 1'b0; utx_done = 1'b0;
        total++; if (pending !== 4'b0101) begin bad++; $display("FAIL b2b_pend got=%b want=0101", pending); end
        step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd0 || vector_addr !== 32'h8000_0008) begin bad++; $display("FAIL b2b_exc got=%b/%0d/%h want=1/0/80000008", irq_out, cause, vector_addr); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (pending !== 4'b0100 || in_service !== 1'b1) begin bad++; $display("FAIL b2b_ack got=%b/%b want=0100/1", pending, in_service); end
        eret = 1'b1; step(); eret = 1'b0;
        total++; if (irq_out !== 1'b0 || in_service !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b/%b want=0/0", irq_out, in_service); end
        step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd2 || vector_addr !== 32'h8000_000C) begin bad++; $display("FAIL b2b_utx got=%b/%0d/%h want=1/2/8000000c", irq_out, cause, vector_addr); end
        ack_and_return();
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL b2b_clear got=%b want=0000", pending); end
    endtask

    task automatic test_timer_level();
        int extra;
        timer_irq = 1'b1; step(); step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd1 || vector_addr !== 32'h8000_0004) begin bad++; $display("FAIL tmr_first got=%b/%0d/%h want=1/1/80000004", irq_out, cause, vector_addr); end
        ack_and_return();
        extra = 0;
        for (int i = 0; i < 46; i++) begin
            step();
            if (irq_out === 1'b1 || pending !== 4'b0000) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL tmr_held_refire got=%0d cycles want=0", extra); end
        timer_irq = 1'b0; step();
        timer_irq = 1'b1; step(); step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd1) begin bad++; $display("FAIL tmr_second got=%b/%0d want=1/1", irq_out, cause); end
        ack_and_return();
        timer_irq = 1'b0; step();
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 4'b0011; step(); mask_we = 1'b0; mask_wdata = 4'b0000;
        timer_irq = 1'b1; step(); timer_irq = 1'b0; step(); step();
        total++; if (pending !== 4'b0010 || irq_out !== 1'b0) begin bad++; $display("FAIL mask_tmr got=%b/%b want=0010/0", pending, irq_out); end
        exc_req = 1'b1; step(); exc_req = 1'b0; step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd0 || vector_addr !== 32'h8000_0008) begin bad++; $display("FAIL mask_exc got=%b/%0d/%h want=1/0/80000008", irq_out, cause, vector_addr); end
        ack_and_return();
        step();
        total++; if (pending !== 4'b0010 || irq_out !== 1'b0) begin bad++; $display("FAIL mask_still got=%b/%b want=0010/0", pending, irq_out); end
        mask_we = 1'b1; step(); mask_we = 1'b0;
        total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL mask_wr_lat got=%b want=0", irq_out); end
        step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd1) begin bad++; $display("FAIL mask_unmask got=%b/%0d want=1/1", irq_out, cause); end
        ack_and_return();
    endtask

    task automatic test_kernel_and_svc();
        kernel_mode = 1'b1;
        urx_done = 1'b1; step(); urx_done = 1'b0; step(); step();
        total++; if (irq_out !== 1'b0 || pending !== 4'b1000) begin bad++; $display("FAIL kern_block got=%b/%b want=0/1000", irq_out, pending); end
        kernel_mode = 1'b0; step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd3) begin bad++; $display("FAIL kern_release got=%b/%0d want=1/3", irq_out, cause); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        urx_done = 1'b1; step(); urx_done = 1'b0; step();
        total++; if (pending !== 4'b1000 || irq_out !== 1'b0 || in_service !== 1'b1) begin bad++; $display("FAIL svc_hold got=%b/%b/%b want=1000/0/1", pending, irq_out, in_service); end
        eret = 1'b1; step(); eret = 1'b0; step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd3) begin bad++; $display("FAIL svc_after got=%b/%0d want=1/3", irq_out, cause); end
        ack_and_return();
    endtask

    task automatic test_reset_mid();
        mask_we = 1'b1; mask_wdata = 4'b1000; step(); mask_we = 1'b0; mask_wdata = 4'b0000;
        timer_irq = 1'b1; utx_done = 1'b1; step(); utx_done = 1'b0; step();
        total++; if (irq_out !== 1'b1 || pending !== 4'b0110) begin bad++; $display("FAIL rst_setup got=%b/%b want=1/0110", irq_out, pending); end
        #2 reset = 1'b1; timer_irq = 1'b0;
        #1;
        total++; if (irq_out !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b0) begin bad++; $display("FAIL rst_async got=%b/%b/%b want=0/0000/0", irq_out, pending, in_service); end
        total++; if (cause !== 2'd0 || vector_addr !== 32'h0) begin bad++; $display("FAIL rst_async_vec got=%0d/%h want=0/0", cause, vector_addr); end
        step(); reset = 1'b0;
        urx_done = 1'b1; step(); urx_done = 1'b0; step();
        total++; if (irq_out !== 1'b1 || cause !== 2'd3) begin bad++; $display("FAIL rst_mask_clr got=%b/%0d want=1/3", irq_out, cause); end
        ack_and_return();
    endtask

    initial begin
        test_reset();
        test_urx_basic();
        test_back_to_back();
        test_timer_level();
        test_mask();
        test_kernel_and_svc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
